// File: rtl/sb_defs.sv
// Shared store-buffer definitions: line count and index/mask types.
package sb_defs;

    localparam int unsigned SB_NO_OF_LINES = 8;

    typedef logic [$clog2(SB_NO_OF_LINES)-1:0] sb_idx_t;
    typedef logic [SB_NO_OF_LINES-1:0]         sb_mask_t;

endpackage

// File: rtl/sb_idx_decoder.sv
// Line index to one-hot line select; all-zero when disabled.
module sb_idx_decoder
    import sb_defs::*;
#(
    parameter  int unsigned NUM_LINES = SB_NO_OF_LINES,
    localparam int unsigned IDX_W     = $clog2(NUM_LINES)
) (
    input  logic [IDX_W-1:0]     idx_i,
    input  logic                 en_i,
    output logic [NUM_LINES-1:0] sel_o
);

    always_comb begin
        sel_o = '0;
        if (en_i) begin
            sel_o[idx_i] = 1'b1;
        end
    end

endmodule

// File: rtl/sb_line_tracker.sv
// Store-buffer line occupancy tracker: lowest-free allocation, oldest-first drain.
// Optional SB_OCCUPANCY_CNT_EN adds occupancy_o and almost_full_o ports.
module sb_line_tracker
    import sb_defs::*;
#(
    parameter  int unsigned NUM_LINES = SB_NO_OF_LINES,
    localparam int unsigned IDX_W     = $clog2(NUM_LINES)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 alloc_req_i,
    output logic                 alloc_gnt_o,
    output logic [IDX_W-1:0]     alloc_idx_o,
    output logic                 drain_valid_o,
    input  logic                 drain_ready_i,
    output logic [IDX_W-1:0]     drain_idx_o,
    output logic [NUM_LINES-1:0] drain_sel_o,
    output logic [NUM_LINES-1:0] line_valid_o,
    output logic                 full_o,
    output logic                 empty_o
`ifdef SB_OCCUPANCY_CNT_EN
    ,
    output logic [IDX_W:0]       occupancy_o,
    output logic                 almost_full_o
`endif
);

    localparam logic [IDX_W:0] FullCnt = NUM_LINES[IDX_W:0];

    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [NUM_LINES-1:0] alloc_mask, drain_clr;
    logic [IDX_W-1:0]     q_q [NUM_LINES];
    logic [IDX_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [IDX_W:0]       count_q, count_d;
    logic                 alloc_fire, drain_fire;

    assign full_o        = (count_q == FullCnt);
    assign empty_o       = (count_q == '0);
    assign alloc_gnt_o   = alloc_req_i && !full_o;
    assign drain_valid_o = !empty_o;
    assign alloc_fire    = alloc_gnt_o;
    assign drain_fire    = drain_valid_o && drain_ready_i;
    assign drain_idx_o   = empty_o ? '0 : q_q[rd_ptr_q];
    assign line_valid_o  = valid_q;

`ifdef SB_OCCUPANCY_CNT_EN
    assign occupancy_o   = count_q;
    assign almost_full_o = (count_q >= FullCnt - 1'b1);
`endif

    // Scan the registered bitmap, so a line draining this cycle is never re-offered.
    always_comb begin
        logic found;
        found       = 1'b0;
        alloc_idx_o = '0;
        for (int i = 0; i < int'(NUM_LINES); i++) begin
            if (!found && !valid_q[i]) begin
                alloc_idx_o = IDX_W'(i);
                found       = 1'b1;
            end
        end
    end

    sb_idx_decoder #(
        .NUM_LINES (NUM_LINES)
    ) u_drain_dec (
        .idx_i (drain_idx_o),
        .en_i  (drain_valid_o),
        .sel_o (drain_sel_o)
    );

    sb_idx_decoder #(
        .NUM_LINES (NUM_LINES)
    ) u_alloc_dec (
        .idx_i (alloc_idx_o),
        .en_i  (alloc_fire),
        .sel_o (alloc_mask)
    );

    assign drain_clr = drain_fire ? drain_sel_o : '0;
    assign valid_d   = (valid_q & ~drain_clr) | alloc_mask;

    always_comb begin
        count_d = count_q;
        case ({alloc_fire, drain_fire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
            if (alloc_fire) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (drain_fire) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Queue entries are only read while occupied, so they need no reset.
    always_ff @(posedge clk) begin
        if (rst_n && alloc_fire) begin
            q_q[wr_ptr_q] <= alloc_idx_o;
        end
    end

endmodule

// File: tb/tb_sb_line_tracker.sv
// Directed self-checking bench for sb_line_tracker (8 lines).
module tb_sb_line_tracker;
    import sb_defs::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       alloc_req_i;
    logic       alloc_gnt_o;
    sb_idx_t    alloc_idx_o;
    logic       drain_valid_o;
    logic       drain_ready_i;
    sb_idx_t    drain_idx_o;
    sb_mask_t   drain_sel_o;
    sb_mask_t   line_valid_o;
    logic       full_o;
    logic       empty_o;
`ifdef SB_OCCUPANCY_CNT_EN
    logic [3:0] occupancy_o;
    logic       almost_full_o;
`endif

    int vectors    = 0;
    int miscompares = 0;
    int exp_wrap [8] = '{4, 5, 6, 7, 0, 1, 2, 3};

    always #5 clk = ~clk;

    sb_line_tracker u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .alloc_req_i   (alloc_req_i),
        .alloc_gnt_o   (alloc_gnt_o),
        .alloc_idx_o   (alloc_idx_o),
        .drain_valid_o (drain_valid_o),
        .drain_ready_i (drain_ready_i),
        .drain_idx_o   (drain_idx_o),
        .drain_sel_o   (drain_sel_o),
        .line_valid_o  (line_valid_o),
        .full_o        (full_o),
        .empty_o       (empty_o)
`ifdef SB_OCCUPANCY_CNT_EN
        ,
        .occupancy_o   (occupancy_o),
        .almost_full_o (almost_full_o)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".empty"},       32'(empty_o),       32'd1);
        chk({tag, ".full"},        32'(full_o),        32'd0);
        chk({tag, ".drain_valid"}, 32'(drain_valid_o), 32'd0);
        chk({tag, ".drain_sel"},   32'(drain_sel_o),   32'h00);
        chk({tag, ".drain_idx"},   32'(drain_idx_o),   32'd0);
        chk({tag, ".alloc_idx"},   32'(alloc_idx_o),   32'd0);
        chk({tag, ".line_valid"},  32'(line_valid_o),  32'h00);
`ifdef SB_OCCUPANCY_CNT_EN
        chk({tag, ".occupancy"},   32'(occupancy_o),   32'd0);
`endif
    endtask

    initial begin
        rst_n = 1'b0; alloc_req_i = 1'b0; drain_ready_i = 1'b0;
        tick();
        chk_reset_outputs("reset");

        // 1: eight allocations fill lines 0..7, ninth is refused
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            alloc_req_i = 1'b1;
            #1;
            chk($sformatf("fill%0d.idx", i), 32'(alloc_idx_o), 32'(i));
            chk($sformatf("fill%0d.gnt", i), 32'(alloc_gnt_o), 32'd1);
            tick();
        end
        #1;
        chk("fill.full",       32'(full_o),       32'd1);
        chk("fill.line_valid", 32'(line_valid_o), 32'hFF);
        chk("fill.ninth_gnt",  32'(alloc_gnt_o),  32'd0);
        chk("fill.ninth_idx",  32'(alloc_idx_o),  32'd0);
`ifdef SB_OCCUPANCY_CNT_EN
        chk("fill.occupancy",  32'(occupancy_o),   32'd8);
        chk("fill.almost",     32'(almost_full_o), 32'd1);
`endif

        // 2: drain the three oldest
        alloc_req_i = 1'b0; drain_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("drain%0d.valid", k), 32'(drain_valid_o), 32'd1);
            chk($sformatf("drain%0d.idx", k),   32'(drain_idx_o),   32'(k));
            chk($sformatf("drain%0d.sel", k),   32'(drain_sel_o),   32'(1) << k);
            tick();
        end
        drain_ready_i = 1'b0;
        #1;
        chk("drain3.line_valid", 32'(line_valid_o), 32'hF8);
        chk("drain3.full",       32'(full_o),       32'd0);

        // 3: refill lowest free lines 0, 1, 2
        alloc_req_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("refill%0d.idx", i), 32'(alloc_idx_o), 32'(i));
            tick();
        end
        alloc_req_i = 1'b0;
        #1;
        chk("refill.full", 32'(full_o), 32'd1);

        // 4: full with both requests: no grant, head line 3 drains, then reallocated
        alloc_req_i = 1'b1; drain_ready_i = 1'b1;
        #1;
        chk("both_full.gnt",       32'(alloc_gnt_o), 32'd0);
        chk("both_full.drain_idx", 32'(drain_idx_o), 32'd3);
        tick();
        drain_ready_i = 1'b0;
        #1;
        chk("both_full.line_valid", 32'(line_valid_o), 32'hF7);
        chk("freed.gnt",            32'(alloc_gnt_o),  32'd1);
        chk("freed.idx",            32'(alloc_idx_o),  32'd3);
        tick();
        alloc_req_i = 1'b0;

        // Order is preserved across the queue wrap
        drain_ready_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk($sformatf("wrap%0d.idx", k), 32'(drain_idx_o), 32'(exp_wrap[k]));
            tick();
        end
        #1;
        chk("wrap.empty",      32'(empty_o),      32'd1);
        chk("wrap.line_valid", 32'(line_valid_o), 32'h00);

        // 5: empty with both requests: allocate only, drain offered next cycle
        alloc_req_i = 1'b1;
        #1;
        chk("both_empty.gnt",   32'(alloc_gnt_o),   32'd1);
        chk("both_empty.idx",   32'(alloc_idx_o),   32'd0);
        chk("both_empty.valid", 32'(drain_valid_o), 32'd0);
        tick();
        alloc_req_i = 1'b0; drain_ready_i = 1'b0;
        #1;
        chk("after_empty.valid",      32'(drain_valid_o), 32'd1);
        chk("after_empty.drain_idx",  32'(drain_idx_o),   32'd0);
        chk("after_empty.line_valid", 32'(line_valid_o),  32'h01);

        // Simultaneous alloc + drain with one entry: line 0 out, line 1 in
        alloc_req_i = 1'b1; drain_ready_i = 1'b1;
        #1;
        chk("swap.alloc_idx", 32'(alloc_idx_o), 32'd1);
        chk("swap.drain_sel", 32'(drain_sel_o), 32'h01);
        tick();
        alloc_req_i = 1'b0; drain_ready_i = 1'b0;
        #1;
        chk("swap.line_valid", 32'(line_valid_o), 32'h02);
        chk("swap.drain_idx",  32'(drain_idx_o),  32'd1);

        // 6: five lines valid, then reset with drain and alloc requested
        alloc_req_i = 1'b1;
        repeat (4) tick();
        alloc_req_i = 1'b0;
        #1;
        chk("five.line_valid", 32'(line_valid_o), 32'h1F);
        rst_n = 1'b0; drain_ready_i = 1'b1; alloc_req_i = 1'b1;
        tick();
        alloc_req_i = 1'b0; drain_ready_i = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        rst_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
